// File: rtl/ysyx_22040750_pipe_skid_reg_if.sv
// Handshake/data bundle between a pipeline producer, the skid register stage
// and its downstream consumer.
//   slave  : the stage itself (takes I_* from upstream/downstream, drives O_*)
//   master : the environment around the stage (drives I_*, observes O_*)
// Signals:
//   I_valid/I_pc/I_inst : upstream word
//   I_allowout          : downstream ready
//   I_stall             : hold the head word (decode/hazard stall)
//   I_flush             : redirect this cycle
//   O_allowin           : stage can take a word this cycle
//   O_valid/O_pc/O_inst : head word toward downstream
//   O_bubble            : head entry is an inserted bubble
//   O_count             : occupancy
interface ysyx_22040750_pipe_skid_reg_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 2
);
  logic              I_valid;
  logic [PC_W-1:0]   I_pc;
  logic [INST_W-1:0] I_inst;
  logic              I_allowout;
  logic              I_stall;
  logic              I_flush;
  logic              O_allowin;
  logic              O_valid;
  logic [PC_W-1:0]   O_pc;
  logic [INST_W-1:0] O_inst;
  logic              O_bubble;
  logic [CNT_W-1:0]  O_count;

  modport slave (
    input  I_valid, I_pc, I_inst, I_allowout, I_stall, I_flush,
    output O_allowin, O_valid, O_pc, O_inst, O_bubble, O_count
  );

  modport master (
    output I_valid, I_pc, I_inst, I_allowout, I_stall, I_flush,
    input  O_allowin, O_valid, O_pc, O_inst, O_bubble, O_count
  );
endinterface

// File: rtl/ysyx_22040750_pipe_skid_reg.sv
// DEPTH-entry circular pipeline register carrying {pc, inst, bubble}.
// Keeps the valid/allowin/allowout/stall handshake of the classic IF/ID latch
// and adds flush handling: drop the incoming word (FLUSH_MODE=0) or replace it
// with a bubble that reuses the last real pc (FLUSH_MODE=1).
// Ports:
//   I_sys_clk : clock, rising edge
//   I_rst     : asynchronous, active-high reset
//   bus       : slave side of ysyx_22040750_pipe_skid_reg_if (handshake + data)
module ysyx_22040750_pipe_skid_reg #(
  parameter int                PC_W        = 32,
  parameter int                INST_W      = 32,
  parameter int                DEPTH       = 2,
  parameter int                FLUSH_MODE  = 1,
  parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(32'h0000_0013),
  parameter int                CNT_W       = $clog2(DEPTH + 1)
) (
  input logic                          I_sys_clk,
  input logic                          I_rst,
  ysyx_22040750_pipe_skid_reg_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit DROP_ON_FLUSH = (FLUSH_MODE == 0);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              bubble;
  } ent_t;

  ent_t             mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  last_pc_q;

  logic empty, full, vld, pop, allowin, push, ins_bubble;
  ent_t wr_ent, head;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign vld     = !empty && !bus.I_stall;
  assign pop     = vld && bus.I_allowout;
  // A pop in the same cycle frees a slot, so a full buffer still streams.
  assign allowin = !full || pop;
  assign push    = bus.I_valid && allowin && !(bus.I_flush && DROP_ON_FLUSH);

  assign ins_bubble = bus.I_flush && !DROP_ON_FLUSH;

  always_comb begin
    wr_ent = '{pc: bus.I_pc, inst: bus.I_inst, bubble: 1'b0};
    if (ins_bubble) wr_ent = '{pc: last_pc_q, inst: BUBBLE_INST, bubble: 1'b1};
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (bus.I_flush) begin
      // Everything not popped this cycle is discarded; the head becomes the
      // slot written now (or the empty slot at wr_ptr if nothing was pushed).
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      cnt_d    = push ? CNT_W'(1) : '0;
    end else begin
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      last_pc_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (push && !ins_bubble) last_pc_q <= bus.I_pc;
    end
  end

  // Entries are cleared on reset so the stale head reads as zero afterwards.
  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_ent;
    end
  end

  // Head slot is shown unconditionally, including stale data when empty.
  assign head = mem_q[rd_ptr_q];

  assign bus.O_allowin = allowin;
  assign bus.O_valid   = vld;
  assign bus.O_pc      = head.pc;
  assign bus.O_inst    = head.inst;
  assign bus.O_bubble  = head.bubble;
  assign bus.O_count   = cnt_q;
endmodule

// File: tb/tb_ysyx_22040750_pipe_skid_reg.sv
module tb_ysyx_22040750_pipe_skid_reg;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, allowout, stall, flush;
  logic [31:0] pc, inst;

  always #5 clk = ~clk;

  // Three instances share one stimulus: DEPTH=2 bubble mode, DEPTH=3 drop mode,
  // DEPTH=4 bubble mode.
  ysyx_22040750_pipe_skid_reg_if #(.PC_W(32), .INST_W(32), .CNT_W(2)) b0 ();
  ysyx_22040750_pipe_skid_reg_if #(.PC_W(32), .INST_W(32), .CNT_W(2)) b1 ();
  ysyx_22040750_pipe_skid_reg_if #(.PC_W(32), .INST_W(32), .CNT_W(3)) b2 ();

  ysyx_22040750_pipe_skid_reg #(.PC_W(32), .INST_W(32), .DEPTH(2), .FLUSH_MODE(1),
    .BUBBLE_INST(32'h13), .CNT_W(2)) u0 (.I_sys_clk(clk), .I_rst(rst), .bus(b0));
  ysyx_22040750_pipe_skid_reg #(.PC_W(32), .INST_W(32), .DEPTH(3), .FLUSH_MODE(0),
    .BUBBLE_INST(32'h13), .CNT_W(2)) u1 (.I_sys_clk(clk), .I_rst(rst), .bus(b1));
  ysyx_22040750_pipe_skid_reg #(.PC_W(32), .INST_W(32), .DEPTH(4), .FLUSH_MODE(1),
    .BUBBLE_INST(32'h13), .CNT_W(3)) u2 (.I_sys_clk(clk), .I_rst(rst), .bus(b2));

  assign b0.I_valid = valid;  assign b1.I_valid = valid;  assign b2.I_valid = valid;
  assign b0.I_pc    = pc;     assign b1.I_pc    = pc;     assign b2.I_pc    = pc;
  assign b0.I_inst  = inst;   assign b1.I_inst  = inst;   assign b2.I_inst  = inst;
  assign b0.I_allowout = allowout; assign b1.I_allowout = allowout; assign b2.I_allowout = allowout;
  assign b0.I_stall = stall;  assign b1.I_stall = stall;  assign b2.I_stall = stall;
  assign b0.I_flush = flush;  assign b1.I_flush = flush;  assign b2.I_flush = flush;

  logic        ov[3], oa[3], ob[3];
  logic [31:0] opc[3], oin[3];
  logic [3:0]  ocnt[3];
  assign ov[0] = b0.O_valid;   assign ov[1] = b1.O_valid;   assign ov[2] = b2.O_valid;
  assign oa[0] = b0.O_allowin; assign oa[1] = b1.O_allowin; assign oa[2] = b2.O_allowin;
  assign ob[0] = b0.O_bubble;  assign ob[1] = b1.O_bubble;  assign ob[2] = b2.O_bubble;
  assign opc[0] = b0.O_pc;     assign opc[1] = b1.O_pc;     assign opc[2] = b2.O_pc;
  assign oin[0] = b0.O_inst;   assign oin[1] = b1.O_inst;   assign oin[2] = b2.O_inst;
  assign ocnt[0] = {2'b0, b0.O_count};
  assign ocnt[1] = {2'b0, b1.O_count};
  assign ocnt[2] = {1'b0, b2.O_count};

  // Reference model: each instance is an ordered list of words (index 0 = head).
  logic [31:0] m_pc  [3][8];
  logic [31:0] m_inst[3][8];
  logic        m_bub [3][8];
  int          m_cnt [3];
  logic [31:0] m_last[3];

  int ntests = 0;
  int nfail  = 0;

  function automatic int dep(int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 4;
  endfunction

  function automatic bit bubble_mode(int k);
    return (k != 1);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]  = 0;
      m_last[k] = '0;
    end
  endtask

  // Directed expectation on the registered state of one instance.
  task automatic expect_state(string tag, int k, int cnt, logic [31:0] hpc,
                              logic [31:0] hinst, logic hbub);
    check($sformatf("%s.u%0d.count", tag, k), 32'(ocnt[k]), 32'(cnt));
    if (cnt > 0) begin
      check($sformatf("%s.u%0d.pc", tag, k), opc[k], hpc);
      check($sformatf("%s.u%0d.inst", tag, k), oin[k], hinst);
      check($sformatf("%s.u%0d.bubble", tag, k), 32'(ob[k]), 32'(hbub));
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, advance the model, then cross the rising edge.
  task automatic step(string tag, bit v, logic [31:0] p, bit ao, bit st, bit fl);
    valid = v; pc = p; inst = p ^ 32'h5A5A_0000; allowout = ao; stall = st; flush = fl;
    #1;
    for (int k = 0; k < 3; k++) begin
      int n;
      bit e_vld, e_pop, e_ain, e_push, e_bub;
      n      = m_cnt[k];
      e_vld  = (n > 0) && !st;
      e_pop  = e_vld && ao;
      e_ain  = (n < dep(k)) || e_pop;
      e_push = v && e_ain && !(fl && !bubble_mode(k));
      check($sformatf("%s.u%0d.valid", tag, k), 32'(ov[k]), 32'(e_vld));
      check($sformatf("%s.u%0d.allowin", tag, k), 32'(oa[k]), 32'(e_ain));
      check($sformatf("%s.u%0d.count", tag, k), 32'(ocnt[k]), 32'(n));
      if (n > 0) begin
        check($sformatf("%s.u%0d.pc", tag, k), opc[k], m_pc[k][0]);
        check($sformatf("%s.u%0d.inst", tag, k), oin[k], m_inst[k][0]);
        check($sformatf("%s.u%0d.bubble", tag, k), 32'(ob[k]), 32'(m_bub[k][0]));
      end
      if (e_pop) begin
        for (int j = 0; j < 7; j++) begin
          m_pc[k][j] = m_pc[k][j+1]; m_inst[k][j] = m_inst[k][j+1]; m_bub[k][j] = m_bub[k][j+1];
        end
        n--;
      end
      if (fl) n = 0;
      if (e_push) begin
        e_bub = fl && bubble_mode(k);
        m_pc[k][n]   = e_bub ? m_last[k] : p;
        m_inst[k][n] = e_bub ? 32'h13 : p ^ 32'h5A5A_0000;
        m_bub[k][n]  = e_bub;
        if (!e_bub) m_last[k] = p;
        n++;
      end
      m_cnt[k] = n;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.u%0d.valid", tag, k), 32'(ov[k]), 32'd0);
      check($sformatf("%s.u%0d.allowin", tag, k), 32'(oa[k]), 32'd1);
      check($sformatf("%s.u%0d.count", tag, k), 32'(ocnt[k]), 32'd0);
      check($sformatf("%s.u%0d.pc", tag, k), opc[k], 32'd0);
      check($sformatf("%s.u%0d.inst", tag, k), oin[k], 32'd0);
      check($sformatf("%s.u%0d.bubble", tag, k), 32'(ob[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 0; pc = '0; inst = '0; allowout = 0; stall = 0; flush = 0;
    @(posedge clk); #1;
    do_reset("por");

    // Asynchronous reset mid-stream: no clock edge between assert and check.
    step("fill", 1, 32'h10, 1, 1, 0);
    step("fill", 1, 32'h14, 1, 1, 0);
    expect_state("fill", 0, 2, 32'h10, 32'h10 ^ 32'h5A5A_0000, 0);
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("arst.u%0d.valid", k), 32'(ov[k]), 32'd0);
      check($sformatf("arst.u%0d.count", k), 32'(ocnt[k]), 32'd0);
      check($sformatf("arst.u%0d.allowin", k), 32'(oa[k]), 32'd1);
    end
    #1;
    rst = 1'b0;
    step("post_rst", 1, 32'h8000_0000, 1, 0, 0);
    expect_state("post_rst", 0, 1, 32'h8000_0000, 32'h8000_0000 ^ 32'h5A5A_0000, 0);
    step("drain", 0, 32'h0, 1, 0, 0);

    // Streaming: each word on the outputs one cycle after its push, count 1.
    do_reset("rst2");
    for (int i = 0; i < 3; i++) begin
      step("stream", 1, 32'h8000_0000 + 32'(4 * i), 1, 0, 0);
      expect_state("stream", 0, 1, 32'h8000_0000 + 32'(4 * i),
                   (32'h8000_0000 + 32'(4 * i)) ^ 32'h5A5A_0000, 0);
    end
    step("stream_end", 0, 32'h0, 1, 0, 0);

    // Backpressure on the DEPTH=2 instance: counts 1, 2, 2, third word held.
    do_reset("rst3");
    step("bp", 1, 32'h200, 1, 1, 0);
    expect_state("bp1", 0, 1, 32'h200, 32'h200 ^ 32'h5A5A_0000, 0);
    step("bp", 1, 32'h204, 1, 1, 0);
    expect_state("bp2", 0, 2, 32'h200, 32'h200 ^ 32'h5A5A_0000, 0);
    check("bp.u0.allowin_full", 32'(oa[0]), 32'd0);
    step("bp", 1, 32'h208, 1, 1, 0);
    expect_state("bp3", 0, 2, 32'h200, 32'h200 ^ 32'h5A5A_0000, 0);
    step("bp_rel", 1, 32'h208, 1, 0, 0);
    step("bp_drain", 0, 32'h0, 1, 0, 0);
    step("bp_drain", 0, 32'h0, 1, 0, 0);
    step("bp_drain", 0, 32'h0, 1, 0, 0);

    // Flush without pop: bubble mode keeps one bubble, drop mode empties.
    do_reset("rst4");
    step("fl_fill", 1, 32'h100, 1, 1, 0);
    step("fl_fill", 1, 32'h104, 1, 1, 0);
    step("flush", 1, 32'h200, 1, 1, 1);
    expect_state("flush_bub", 2, 1, 32'h104, 32'h13, 1);
    expect_state("flush_drop", 1, 0, 32'h0, 32'h0, 0);
    check("flush_drop.u1.valid", 32'(ov[1]), 32'd0);
    step("flush_after", 0, 32'h0, 1, 0, 0);

    // Flush with pop: 0x100 delivered once, 0x104 discarded.
    do_reset("rst6");
    step("fp_fill", 1, 32'h100, 1, 1, 0);
    step("fp_fill", 1, 32'h104, 1, 1, 0);
    step("fp_flush", 0, 32'h0, 1, 0, 1);
    for (int k = 0; k < 3; k++) expect_state("fp_after", k, 0, 32'h0, 32'h0, 0);
    step("fp_idle", 0, 32'h0, 1, 0, 0);

    // Randomised traffic against the model.
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(3) != 0), $urandom, ($urandom_range(3) != 0),
           ($urandom_range(3) == 0), ($urandom_range(15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/ysyx_22040750_pipe_skid_reg.md
Name: ysyx_22040750_pipe_skid_reg

Overview:
Parametrised pipeline stage register for the in-order core. It generalises the single-entry IF/ID latch into a DEPTH-entry circular buffer carrying {pc, inst, bubble flag}. It keeps the valid/allowin/allowout/stall handshake and adds selectable flush behaviour: drop the incoming word, or replace it with a bubble. It is instantiated between IF and ID, and optionally between later stages, so a slow fetch or stalled decode does not lose throughput.

Parameters:
PC_W, 32, width of pc field
INST_W, 32, width of instruction field
DEPTH, 2, number of buffer entries; legal range 1..8 (DEPTH=1 is the classic single latch)
FLUSH_MODE, 1, 0 = drop incoming word on flush; 1 = replace incoming word with bubble
BUBBLE_INST, 32'h00000013, instruction written for a bubble (addi x0,x0,0)
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
I_sys_clk  in  1  clock, rising edge
I_rst  in  1  asynchronous, active-high reset
I_valid  in  1  upstream word valid
I_pc  in  PC_W  upstream pc
I_inst  in  INST_W  upstream instruction
I_allowout  in  1  downstream ready to accept
I_stall  in  1  hold output (decoder/hazard stall)
I_flush  in  1  jump/redirect this cycle
O_allowin  out  1  stage can accept a word this cycle
O_valid  out  1  head word valid toward downstream
O_pc  out  PC_W  head pc
O_inst  out  INST_W  head instruction
O_bubble  out  1  head entry is an inserted bubble (debug)
O_count  out  CNT_W  number of stored entries

Behaviour:
- Reset is asynchronous and active-high. While I_rst is asserted: count=0, rd/wr pointers=0, all entries {0,0,0}, last_pc=0. Hence O_valid=0, O_pc=0, O_inst=0, O_bubble=0, O_count=0, O_allowin=1. Reset mid-operation discards all entries immediately.
- empty = (count==0); full = (count==DEPTH).
- O_valid = !empty && !I_stall.
- pop = O_valid && I_allowout.
- O_allowin = !full || pop. Combinational; the same-cycle pop frees a slot.
- push = I_valid && O_allowin && !(I_flush && FLUSH_MODE==0).
- O_pc, O_inst and O_bubble always show the head slot (mem[rd_ptr]), also when empty (stale data). Zero-latency output: a word written at edge N is on the outputs after edge N if the buffer was empty.
- On push the write data is:
  - normal: {I_pc, I_inst, 0}
  - I_flush with FLUSH_MODE==1: {last_pc, BUBBLE_INST, 1}
- last_pc updates to I_pc only on a non-bubble push.
- Flush clears stored entries:
  - All entries not popped this cycle are discarded: count becomes (push?1:0) and rd_ptr moves to the slot written this cycle (or to wr_ptr if nothing was pushed).
  - A pop in the flush cycle completes normally; downstream keeps that word.
- Without flush:
  - count_next = count + push - pop
  - pointers advance mod DEPTH on push/pop
  - simultaneous push and pop when full is legal, and count is unchanged.
- I_stall blocks pop only; pushes continue until full.
- Pushing when full without a pop is impossible because O_allowin=0. An I_valid presented then is held upstream, not lost.
- O_count equals count.
- DEPTH=1 with FLUSH_MODE=1 reproduces single-latch IF/ID timing exactly.

Test Plan:
1. Reset mid-stream: fill 2 entries, assert I_rst asynchronously (between clock edges) -> O_valid=0, O_count=0, O_allowin=1 with no clock edge; after release the first push of pc=0x80000000 appears on the next edge.
2. Streaming, DEPTH=2, I_allowout=1: push pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles -> each appears on O_pc one cycle after its push; O_count stays 1; no bubbles.
3. Backpressure: I_stall=1 for 3 cycles while pushing 3 words -> O_count goes 1, 2, 2; O_allowin=0 at count 2; the third word is held upstream; on stall release the words drain in order.
4. Flush, FLUSH_MODE=1: buffer holds pcs 0x100 and 0x104, last_pc=0x104, I_flush with I_valid and pc=0x200, no pop -> next cycle O_count=1, O_pc=0x104, O_inst=0x00000013, O_bubble=1.
5. Flush, FLUSH_MODE=0: same stimulus -> O_count=0 and O_valid=0 next cycle; pc 0x200 is not stored.
6. Flush with simultaneous pop: head 0x100 accepted in the flush cycle -> downstream sees 0x100 once; entry 0x104 is discarded and never appears on the outputs.
